spi_master: RTL

- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, matching the existing SPI slave.
- Gives on-chip logic a ready/start byte interface, and drives sck/mosi/ssel to an external or on-board slave.
- Groups bytes into frames: ssel stays asserted until a byte tagged "last" completes.
- Used by board-level test logic to exercise the slave end and to talk to SPI peripherals.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sck_gen.sv | 38 +++
 rtl/spi_master.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master and its matching slave:
// FSM state encoding, mode constants and timing limits.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4,
    ST_TRAIL = 3'd5,
    ST_DESEL = 3'd6
  } spi_state_e;

  localparam logic SPI_MODE0_CPOL = 1'b0;
  localparam logic SPI_MODE0_CPHA = 1'b0;

  localparam int SPI_DEFAULT_DATA_WIDTH = 8;

  // The slave oversamples sck, so each half-period needs at least this many clk cycles.
  localparam int SPI_MIN_CLK_DIV = 4;

  // States in which a new byte may be accepted.
  function automatic logic spi_accepting(input spi_state_e s);
    return (s == ST_IDLE) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period timer for the SPI master: counts 0..CLK_DIV-1 while enabled and
// flags the last cycle of each half-period with a one-cycle tick.
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && !restart && (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first master with a ready/start byte interface.
// Bytes are grouped into frames: ssel stays low until a byte tagged "last" finishes.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = SPI_DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  last,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  ssel
);

  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be at least %0d", SPI_MIN_CLK_DIV);
  end
  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("spi_master: DATA_WIDTH must be at least 2");
  end
  if ((SPI_MODE0_CPOL != 1'b0) || (SPI_MODE0_CPHA != 1'b0)) begin : g_bad_mode
    $error("spi_master: only SPI mode 0 is implemented");
  end

  spi_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  last_q, last_d;
  logic                  sck_q, sck_d;
  logic                  mosi_q, mosi_d;
  logic                  ssel_q, ssel_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  rx_valid_q, rx_valid_d;

  logic                  gen_en;
  logic                  gen_restart;
  logic                  tick;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_next;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (gen_en),
    .restart (gen_restart),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    last_d      = last_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    ssel_d      = ssel_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    gen_en      = 1'b0;
    gen_restart = 1'b0;
    // miso is sampled on the edge that ends the high phase, i.e. as late as possible.
    rx_next     = {rx_shift_q[DATA_WIDTH-2:0], miso};
    tx_next     = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (start && ready_q && spi_accepting(state_q)) begin
          state_d     = ST_LEAD;
          tx_shift_d  = tx_data;
          last_d      = last;
          mosi_d      = tx_data[DATA_WIDTH-1];
          ssel_d      = 1'b0;
          ready_d     = 1'b0;
          busy_d      = 1'b1;
          bit_cnt_d   = '0;
          gen_restart = 1'b1;
        end
      end

      ST_LEAD, ST_LOW: begin
        gen_en = 1'b1;
        if (tick) begin
          sck_d   = 1'b1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        gen_en = 1'b1;
        if (tick) begin
          sck_d      = 1'b0;
          rx_shift_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            // Byte complete: mosi keeps the final bit through GAP/TRAIL.
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            state_d    = last_q ? ST_TRAIL : ST_GAP;
            ready_d    = !last_q;
          end else begin
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
            tx_shift_d = tx_next;
            mosi_d     = tx_next[DATA_WIDTH-1];
            state_d    = ST_LOW;
          end
        end
      end

      ST_TRAIL: begin
        gen_en = 1'b1;
        if (tick) begin
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = ST_DESEL;
        end
      end

      ST_DESEL: begin
        gen_en = 1'b1;
        if (tick) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      sck_q      <= SPI_MODE0_CPOL;
      mosi_q     <= 1'b0;
      ssel_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ssel_q     <= ssel_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign ready    = ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign ssel     = ssel_q;

  a_sck_only_selected: assert property (@(posedge clk) disable iff (!rst_n) sck_q |-> !ssel_q);
  a_rx_valid_pulse:    assert property (@(posedge clk) disable iff (!rst_n) rx_valid_q |=> !rx_valid_q);

endmodule
